// File: rtl/serial_word_serializer_if.sv
// Parallel-in / serial-out bundle between a word producer and the serializer.
// Handshake: a word moves on a rising edge where in_valid && in_ready are both 1;
// the producer may change in_valid/in_data freely at any other time, and
// in_ready depends only on registered state (never combinationally on in_valid).
interface serial_word_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_data;
  logic             ser_tick;
  logic             ser_load;
  logic             busy;
  logic [7:0]       word_count;
  logic             dbg_state;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  ser_data,
    input  ser_tick,
    input  ser_load,
    input  busy,
    input  word_count,
    input  dbg_state
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output ser_data,
    output ser_tick,
    output ser_load,
    output busy,
    output word_count,
    output dbg_state
  );
endinterface

// File: rtl/serial_word_serializer.sv
// Double-buffered word serializer: a holding register feeds a shift register that
// emits one bit every DIV clocks, with a bit strobe and a first-bit frame marker.
module serial_word_serializer #(
  parameter int WIDTH     = 4,
  parameter int DIV       = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic                    input_clock1_clk,
  input  logic                    input_push_button1_rst_n,
  serial_word_serializer_if.slave bus
);

  localparam int            BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] IDX_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_idx_q, bit_idx_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [7:0]       word_count_q, word_count_d;

  logic busy;
  logic tick;
  logic accept;
  logic out_bit;

  assign busy    = (state_q == SHIFT);
  assign tick    = busy && (div_cnt_q == DIV_LAST);
  assign accept  = bus.in_valid && !hold_valid_q;
  assign out_bit = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[WIDTH-1];

  always_ff @(posedge input_clock1_clk or negedge input_push_button1_rst_n) begin
    if (!input_push_button1_rst_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      div_cnt_q    <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shreg_q      <= shreg_d;
      bit_idx_q    <= bit_idx_d;
      div_cnt_q    <= div_cnt_d;
      word_count_q <= word_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shreg_d      = shreg_q;
    bit_idx_d    = bit_idx_q;
    div_cnt_d    = div_cnt_q;
    word_count_d = word_count_q;

    // Accept only writes the hold register; a reload below needs hold_valid_q=1,
    // which blocks accept in the same cycle, so the two never collide.
    if (accept) begin
      hold_d       = bus.in_data;
      hold_valid_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        if (hold_valid_q) begin
          shreg_d      = hold_q;
          hold_valid_d = 1'b0;
          bit_idx_d    = '0;
          state_d      = SHIFT;
        end
      end

      SHIFT: begin
        div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
        if (tick) begin
          if (bit_idx_q != IDX_LAST) begin
            if (LSB_FIRST != 0) begin
              shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end else begin
              shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end
            bit_idx_d = bit_idx_q + BW'(1);
          end else begin
            word_count_d = word_count_q + 8'd1;
            bit_idx_d    = '0;
            // A held word starts on the very next clock so the stream has no gap.
            if (hold_valid_q) begin
              shreg_d      = hold_q;
              hold_valid_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready   = !hold_valid_q;
  assign bus.ser_data   = busy ? out_bit : 1'b1;
  assign bus.ser_tick   = tick;
  assign bus.ser_load   = busy && (bit_idx_q == '0);
  assign bus.busy       = busy;
  assign bus.word_count = word_count_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_serial_word_serializer.sv
// Bench for serial_word_serializer: three configurations side by side, each
// checked every cycle against a word-queue model of the serial stream.
module tb_serial_word_serializer;

  localparam int W     = 4;
  localparam int N_DUT = 3;

  function automatic int div_of(input int g);
    return (g == 2) ? 1 : 4;
  endfunction

  function automatic int lsb_of(input int g);
    return (g == 1) ? 0 : 1;
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         vld    [N_DUT];
  logic [W-1:0] dat    [N_DUT];
  logic         rdy_s  [N_DUT];
  logic         sd_s   [N_DUT];
  logic         tick_s [N_DUT];
  logic         load_s [N_DUT];
  logic         busy_s [N_DUT];
  logic         dbg_s  [N_DUT];
  logic [7:0]   wc_s   [N_DUT];

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    serial_word_serializer_if #(.WIDTH(W)) bus ();

    serial_word_serializer #(
      .WIDTH    (W),
      .DIV      (div_of(g)),
      .LSB_FIRST(lsb_of(g))
    ) dut (
      .input_clock1_clk        (clk),
      .input_push_button1_rst_n(rst_n),
      .bus                     (bus)
    );

    assign bus.in_valid = vld[g];
    assign bus.in_data  = dat[g];
    assign rdy_s[g]     = bus.in_ready;
    assign sd_s[g]      = bus.ser_data;
    assign tick_s[g]    = bus.ser_tick;
    assign load_s[g]    = bus.ser_load;
    assign busy_s[g]    = bus.busy;
    assign dbg_s[g]     = bus.dbg_state;
    assign wc_s[g]      = bus.word_count;
  end

  // ---------------- scoreboard state ----------------
  int           n_pass;
  int           n_checks;
  int           cyc;
  logic [W-1:0] exp_q   [N_DUT][$];
  int           stamp_q [N_DUT][$];
  bit           in_word [N_DUT];
  int           pos     [N_DUT];
  logic [7:0]   wc_exp  [N_DUT];
  int           n_sent  [N_DUT];
  int           busy_cnt[N_DUT];
  int           rise_cnt[N_DUT];
  int           tick_cnt[N_DUT];
  logic         busy_prev[N_DUT];

  task automatic check_eq(input string tag, input int d,
                          input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s dut%0d got=%0h expected=%0h at t=%0t", tag, d, got, exp, $time);
    end
  endtask

  // Accepted words enter the model with the index of the edge that took them.
  always @(posedge clk) begin
    for (int d = 0; d < N_DUT; d++) begin
      if (rst_n && vld[d] && rdy_s[d]) begin
        exp_q[d].push_back(dat[d]);
        stamp_q[d].push_back(cyc);
      end
    end
    cyc = cyc + 1;
  end

  // Each word occupies W*DIV consecutive busy clocks, starting the clock after it
  // was accepted (or right after the previous word), bit k held for DIV clocks.
  always @(negedge clk) begin : monitor
    int           k;
    int           bitn;
    int           held;
    int           dv;
    logic [W-1:0] cur;
    for (int d = 0; d < N_DUT; d++) begin
      dv = div_of(d);
      if (!rst_n) begin
        exp_q[d].delete();
        stamp_q[d].delete();
        in_word[d] = 1'b0;
        pos[d]     = 0;
        wc_exp[d]  = '0;
        check_eq("rst_busy",     d, busy_s[d], 0);
        check_eq("rst_ser_data", d, sd_s[d],   1);
        check_eq("rst_tick",     d, tick_s[d], 0);
        check_eq("rst_load",     d, load_s[d], 0);
        check_eq("rst_in_ready", d, rdy_s[d],  1);
        check_eq("rst_word_cnt", d, wc_s[d],   0);
      end else begin
        if (!in_word[d] && exp_q[d].size() > 0 && stamp_q[d][0] + 1 < cyc) begin
          in_word[d] = 1'b1;
          pos[d]     = 0;
        end
        held = exp_q[d].size() - (in_word[d] ? 1 : 0);
        check_eq("in_ready",   d, rdy_s[d], held == 0);
        check_eq("word_count", d, wc_s[d],  wc_exp[d]);
        check_eq("busy",       d, busy_s[d], in_word[d]);
        check_eq("state",      d, dbg_s[d],  in_word[d]);
        if (in_word[d]) begin
          k    = pos[d] / dv;
          bitn = (lsb_of(d) != 0) ? k : W - 1 - k;
          cur  = exp_q[d][0];
          check_eq("ser_data", d, sd_s[d],   cur[bitn]);
          check_eq("ser_tick", d, tick_s[d], (pos[d] % dv) == dv - 1);
          check_eq("ser_load", d, load_s[d], pos[d] < dv);
          pos[d]++;
          if (pos[d] == W * dv) begin
            void'(exp_q[d].pop_front());
            void'(stamp_q[d].pop_front());
            wc_exp[d]  = wc_exp[d] + 8'd1;
            in_word[d] = 1'b0;
          end
        end else begin
          check_eq("idle_data", d, sd_s[d],   1);
          check_eq("idle_tick", d, tick_s[d], 0);
          check_eq("idle_load", d, load_s[d], 0);
        end
        busy_cnt[d] += busy_s[d] ? 1 : 0;
        tick_cnt[d] += tick_s[d] ? 1 : 0;
        if (busy_s[d] && !busy_prev[d]) rise_cnt[d]++;
      end
      busy_prev[d] = busy_s[d];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input int d, input logic [W-1:0] w);
    bit done;
    done = 1'b0;
    @(negedge clk);
    vld[d] = 1'b1;
    dat[d] = w;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      if (rdy_s[d]) done = 1'b1;
    end
    check_eq("accept_wait", d, done, 1);
    n_sent[d]++;
  endtask

  task automatic idle_for(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vld[d] = 1'b0;
      dat[d] = W'($urandom_range(0, 15));
    end
  endtask

  task automatic wait_drain(input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (exp_q[d].size() == 0 && !busy_s[d]) ok = 1'b1;
    end
    @(negedge clk);
    check_eq("drain_wait", d, ok, 1);
  endtask

  task automatic dir_a();
    int b0, r0, t0;
    b0 = busy_cnt[0]; r0 = rise_cnt[0]; t0 = tick_cnt[0];
    send_word(0, 4'b1011);
    idle_for(0, 1);
    wait_drain(0);
    check_eq("one_word_busy_len", 0, busy_cnt[0] - b0, 16);
    check_eq("one_word_busy_runs", 0, rise_cnt[0] - r0, 1);
    check_eq("one_word_ticks", 0, tick_cnt[0] - t0, 4);
    check_eq("one_word_count", 0, wc_s[0], n_sent[0] % 256);
    b0 = busy_cnt[0]; r0 = rise_cnt[0]; t0 = tick_cnt[0];
    send_word(0, 4'hA);
    send_word(0, 4'h5);
    idle_for(0, 1);
    wait_drain(0);
    check_eq("pair_busy_len", 0, busy_cnt[0] - b0, 32);
    check_eq("pair_busy_runs", 0, rise_cnt[0] - r0, 1);
    check_eq("pair_ticks", 0, tick_cnt[0] - t0, 8);
    check_eq("pair_count", 0, wc_s[0], n_sent[0] % 256);
  endtask

  task automatic dir_b();
    int b0;
    b0 = busy_cnt[1];
    send_word(1, 4'b1000);
    idle_for(1, 1);
    wait_drain(1);
    check_eq("msb_busy_len", 1, busy_cnt[1] - b0, 16);
    check_eq("msb_count", 1, wc_s[1], n_sent[1] % 256);
  endtask

  task automatic dir_c();
    int b0, t0;
    b0 = busy_cnt[2]; t0 = tick_cnt[2];
    send_word(2, 4'b0110);
    idle_for(2, 1);
    wait_drain(2);
    check_eq("div1_busy_len", 2, busy_cnt[2] - b0, 4);
    check_eq("div1_ticks", 2, tick_cnt[2] - t0, 4);
    check_eq("div1_count", 2, wc_s[2], n_sent[2] % 256);
  endtask

  task automatic reset_mid_word();
    bit found;
    int b0;
    found = 1'b0;
    send_word(0, 4'h6);
    send_word(0, 4'h9);
    idle_for(0, 1);
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (in_word[0] && pos[0] >= 9 && pos[0] <= 11) found = 1'b1;
    end
    check_eq("reach_bit2", 0, found, 1);
    check_eq("held_ready", 0, rdy_s[0], 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy",  0, busy_s[0], 0);
    check_eq("async_rst_data",  0, sd_s[0],   1);
    check_eq("async_rst_ready", 0, rdy_s[0],  1);
    check_eq("async_rst_count", 0, wc_s[0],   0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < N_DUT; d++) n_sent[d] = 0;
    b0 = busy_cnt[0];
    repeat (40) @(negedge clk);
    check_eq("post_rst_silent", 0, busy_cnt[0] - b0, 0);
    check_eq("post_rst_count", 0, wc_s[0], 0);
  endtask

  task automatic rand_traffic(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) idle_for(d, $urandom_range(1, 6));
      send_word(d, W'($urandom_range(0, 15)));
    end
    idle_for(d, 1);
    wait_drain(d);
    check_eq("rand_count", d, wc_s[d], n_sent[d] % 256);
  endtask

  task automatic stream_a();
    int b0, r0;
    b0 = busy_cnt[0]; r0 = rise_cnt[0];
    for (int i = 0; i < 256; i++) send_word(0, W'($urandom_range(0, 15)));
    idle_for(0, 1);
    wait_drain(0);
    check_eq("stream_busy_len", 0, busy_cnt[0] - b0, 256 * 16);
    check_eq("stream_busy_runs", 0, rise_cnt[0] - r0, 1);
    check_eq("stream_count_wrap", 0, wc_s[0], n_sent[0] % 256);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_pass   = 0;
    n_checks = 0;
    cyc      = 0;
    for (int d = 0; d < N_DUT; d++) begin
      vld[d]       = 1'b0;
      dat[d]       = '0;
      in_word[d]   = 1'b0;
      pos[d]       = 0;
      wc_exp[d]    = '0;
      n_sent[d]    = 0;
      busy_cnt[d]  = 0;
      rise_cnt[d]  = 0;
      tick_cnt[d]  = 0;
      busy_prev[d] = 1'b0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    fork
      dir_a();
      dir_b();
      dir_c();
    join

    reset_mid_word();

    fork
      rand_traffic(0, 25);
      rand_traffic(1, 25);
      rand_traffic(2, 40);
    join

    stream_a();

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog dut0 got=running expected=finished at t=%0t", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule
